layer_arbiter: RTL and testbench
================================

Name: layer_arbiter

Overview:
- Per-pixel compositor and arbiter that shares the single VGA colour output between four drawing layers (UI text, player A, player B, background sprites).
- Sits between the layer drawing modules and the top-level r/g/b/hs/vs outputs of vga_game, in the pclk domain.
- Timing signals are delayed to match its fixed 2-cycle latency.
- Layer enables and front-player swap are shadowed and updated only at frame boundaries. It also reports per-frame player collision and counts frames.

Parameters:
- BG_RGB, 12'h000, colour driven in active area when no enabled layer requests the pixel.
- FCNT_W, 16, width of frame counter.

Ports:
- pclk  in  1  pixel clock (40 MHz, 1056x628 total frame).
- rst_n  in  1  asynchronous active-low reset.
- hcount_in  in  11  horizontal position from timing generator.
- vcount_in  in  11  vertical position.
- hsync_in, vsync_in  in  1 each  sync from timing generator.
- hblnk_in, vblnk_in  in  1 each  blanking from timing generator.
- req_in  in  4  per-layer opaque-pixel request, bit0=UI, bit1=player A, bit2=player B, bit3=background sprites.
- rgb0_in..rgb3_in  in  12 each  layer colours {r,g,b}.
- cfg_en  in  4  requested layer enable mask (sampled at frame boundary).
- cfg_swap  in  1  1 = player B drawn in front of player A (sampled at frame boundary).
- hcount_out, vcount_out  out  11  delayed by 2.
- hsync_out, vsync_out, hblnk_out, vblnk_out  out  1 each  delayed by 2.
- rgb_out  out  12  composited colour.
- collision  out  1  1 = players overlapped in previous frame.
- frame_tick  out  1  one-cycle pulse at frame boundary.
- frame_cnt  out  FCNT_W  completed-frame count.

Behaviour:
- Reset (async, rst_n=0): all outputs 0; en_sh=4'b1111; swap_sh=0; hit_acc=0; pipeline registers 0; vblnk_prev=0.
- Frame boundary (fb): cycle where vblnk_in=1 and vblnk_prev=0 (registered previous vblnk_in).
- At fb:
  - en_sh<=cfg_en; swap_sh<=cfg_swap.
  - collision<=hit_acc; hit_acc<=0.
  - frame_cnt<=frame_cnt+1, wrapping at 2^FCNT_W.
  - frame_tick=1 for exactly that registered cycle. It is asserted in the cycle after fb, aligned with stage 1.
- Shadowed cfg applies from the pixel arriving in the cycle after fb. Cfg changes outside fb have no effect.
- Effective request: ereq = req_in & en_sh.
- Priority, highest first:
  - swap_sh=0: L0 > L1 > L2 > L3.
  - swap_sh=1: L0 > L2 > L1 > L3.
- Stage 1 (registered):
  - blank_d1 = hblnk_in|vblnk_in.
  - Winning colour; BG_RGB if ereq=0.
  - All timing inputs delayed 1.
- Stage 2 (registered):
  - rgb_out = 12'h000 if blank_d1, else stage-1 colour.
  - Timing outputs delayed a second cycle.
- Latency is exactly 2 pclk for all outputs relative to the same input cycle. There are no bubbles and no stalls.
- Collision accumulation: hit_acc<=1 on any cycle with !hblnk_in && !vblnk_in && ereq[1] && ereq[2]. It is sticky until fb.
  - Disabled player layers never cause a hit.
  - A hit and fb cannot coincide (fb cycle is blanked). If the same-cycle case arises, clear takes priority.
- frame_cnt wraps 16'hFFFF -> 0 with no flag.
- Reset mid-frame: everything returns to reset values immediately. The first fb after release publishes collision=0 unless hits occurred after release.
- Timing generator is free-running. The block never alters sync polarity or values, only delays them.

Test Plan:
- After reset, drive active pixel with req_in=4'b0000 -> two cycles later rgb_out=BG_RGB (12'h000), hsync_out/vsync_out equal inputs delayed 2, collision=0, frame_cnt=0.
- Active pixel, req_in=4'b0110, rgb1=12'hF00, rgb2=12'h00F, swap_sh=0 -> rgb_out=12'hF00. Set cfg_swap=1, cross one fb -> same stimulus gives 12'h00F.
- req_in=4'b1111 with hblnk_in=1 -> rgb_out=12'h000. Same with hblnk_in=0, rgb0=12'h0F0 -> rgb_out=12'h0F0.
- cfg_en=4'b1101 applied mid-frame -> no change until next fb. After fb, req_in=4'b0010 gives BG_RGB.
- Players overlap one active pixel in frame N -> collision=1 from fb ending frame N through the next fb. No overlap in frame N+1 -> collision=0 after the following fb.
- Run 3 full 1056x628 frames -> frame_tick pulses 3 times at 663168-cycle spacing, frame_cnt=3. Preload to 16'hFFFF via forced sim, then one fb -> 0.

Source files
------------

// File: rtl/layer_arbiter.sv
// Two-stage per-pixel compositor for four VGA layers, with frame-boundary
// shadowing of layer enables and player order, player collision report and frame counter.
module layer_arbiter #(
  parameter logic [11:0] BG_RGB = 12'h000,
  parameter int          FCNT_W = 16
) (
  input  logic              pclk,
  input  logic              rst_n,
  input  logic [10:0]       hcount_in,
  input  logic [10:0]       vcount_in,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              hblnk_in,
  input  logic              vblnk_in,
  input  logic [3:0]        req_in,
  input  logic [11:0]       rgb0_in,
  input  logic [11:0]       rgb1_in,
  input  logic [11:0]       rgb2_in,
  input  logic [11:0]       rgb3_in,
  input  logic [3:0]        cfg_en,
  input  logic              cfg_swap,
  output logic [10:0]       hcount_out,
  output logic [10:0]       vcount_out,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic              hblnk_out,
  output logic              vblnk_out,
  output logic [11:0]       rgb_out,
  output logic              collision,
  output logic              frame_tick,
  output logic [FCNT_W-1:0] frame_cnt
);

  logic        r_vblnk_prev;
  logic [3:0]  r_en_sh;
  logic        r_swap_sh;
  logic        r_hit_acc;

  logic [11:0] r_rgb_d1;
  logic        r_blank_d1;
  logic [10:0] r_hcount_d1;
  logic [10:0] r_vcount_d1;
  logic        r_hsync_d1;
  logic        r_vsync_d1;
  logic        r_hblnk_d1;
  logic        r_vblnk_d1;

  logic        w_fb;
  logic        w_hit;
  logic [3:0]  w_ereq;
  logic [11:0] w_win_rgb;

  assign w_fb   = vblnk_in & ~r_vblnk_prev;
  assign w_ereq = req_in & r_en_sh;
  assign w_hit  = ~hblnk_in & ~vblnk_in & w_ereq[1] & w_ereq[2];

  // UI always wins; swap only reorders the two player layers
  always_comb begin
    w_win_rgb = BG_RGB;
    if (w_ereq[0])
      w_win_rgb = rgb0_in;
    else if (r_swap_sh ? w_ereq[2] : w_ereq[1])
      w_win_rgb = r_swap_sh ? rgb2_in : rgb1_in;
    else if (r_swap_sh ? w_ereq[1] : w_ereq[2])
      w_win_rgb = r_swap_sh ? rgb1_in : rgb2_in;
    else if (w_ereq[3])
      w_win_rgb = rgb3_in;
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_vblnk_prev <= 1'b0;
      r_en_sh      <= 4'b1111;
      r_swap_sh    <= 1'b0;
      r_hit_acc    <= 1'b0;
      collision    <= 1'b0;
      frame_tick   <= 1'b0;
      frame_cnt    <= '0;
    end else begin
      r_vblnk_prev <= vblnk_in;
      frame_tick   <= w_fb;
      if (w_fb) begin
        r_en_sh   <= cfg_en;
        r_swap_sh <= cfg_swap;
        collision <= r_hit_acc;
        r_hit_acc <= 1'b0;
        frame_cnt <= frame_cnt + FCNT_W'(1);
      end else if (w_hit) begin
        r_hit_acc <= 1'b1;
      end
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_rgb_d1    <= 12'h000;
      r_blank_d1  <= 1'b0;
      r_hcount_d1 <= 11'd0;
      r_vcount_d1 <= 11'd0;
      r_hsync_d1  <= 1'b0;
      r_vsync_d1  <= 1'b0;
      r_hblnk_d1  <= 1'b0;
      r_vblnk_d1  <= 1'b0;
      rgb_out     <= 12'h000;
      hcount_out  <= 11'd0;
      vcount_out  <= 11'd0;
      hsync_out   <= 1'b0;
      vsync_out   <= 1'b0;
      hblnk_out   <= 1'b0;
      vblnk_out   <= 1'b0;
    end else begin
      r_rgb_d1    <= w_win_rgb;
      r_blank_d1  <= hblnk_in | vblnk_in;
      r_hcount_d1 <= hcount_in;
      r_vcount_d1 <= vcount_in;
      r_hsync_d1  <= hsync_in;
      r_vsync_d1  <= vsync_in;
      r_hblnk_d1  <= hblnk_in;
      r_vblnk_d1  <= vblnk_in;
      rgb_out     <= r_blank_d1 ? 12'h000 : r_rgb_d1;
      hcount_out  <= r_hcount_d1;
      vcount_out  <= r_vcount_d1;
      hsync_out   <= r_hsync_d1;
      vsync_out   <= r_vsync_d1;
      hblnk_out   <= r_hblnk_d1;
      vblnk_out   <= r_vblnk_d1;
    end
  end

endmodule

// File: tb/tb_layer_arbiter.sv
// Directed self-checking bench for layer_arbiter: compositing priority, blanking,
// frame-boundary shadowing, collision reporting and frame counting.
module tb_layer_arbiter;

  logic        pclk = 1'b0;
  logic        rst_n = 1'b1;
  logic [10:0] hcount_in = '0, vcount_in = '0;
  logic        hsync_in = 1'b0, vsync_in = 1'b0, hblnk_in = 1'b0, vblnk_in = 1'b0;
  logic [3:0]  req_in = '0;
  logic [11:0] rgb0_in = '0, rgb1_in = '0, rgb2_in = '0, rgb3_in = '0;
  logic [3:0]  cfg_en = 4'b1111;
  logic        cfg_swap = 1'b0;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;
  logic        collision, frame_tick;
  logic [15:0] frame_cnt;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic [15:0] exp_cnt = '0;

  layer_arbiter dut (
    .pclk(pclk), .rst_n(rst_n),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .req_in(req_in),
    .rgb0_in(rgb0_in), .rgb1_in(rgb1_in), .rgb2_in(rgb2_in), .rgb3_in(rgb3_in),
    .cfg_en(cfg_en), .cfg_swap(cfg_swap),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out),
    .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out), .collision(collision),
    .frame_tick(frame_tick), .frame_cnt(frame_cnt)
  );

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  task automatic pix(input logic [3:0] req, input logic hb, output logic [11:0] got);
    @(negedge pclk);
    req_in = req; hblnk_in = hb; vblnk_in = 1'b0;
    repeat (2) @(posedge pclk);
    #1 got = rgb_out;
  endtask

  task automatic do_fb;
    @(negedge pclk);
    req_in = 4'b0000; hblnk_in = 1'b1; vblnk_in = 1'b0;
    @(negedge pclk);
    vblnk_in = 1'b1;
    @(posedge pclk);
    #1 exp_cnt = exp_cnt + 16'd1;
    checks++;
    if (frame_tick !== 1'b1) begin
      failures++; $display("FAIL fb_tick got=%b exp=1", frame_tick);
    end
    checks++;
    if (frame_cnt !== exp_cnt) begin
      failures++; $display("FAIL fb_cnt got=%h exp=%h", frame_cnt, exp_cnt);
    end
    @(negedge pclk);
    vblnk_in = 1'b0; hblnk_in = 1'b0;
    @(posedge pclk);
    #1 checks++;
    if (frame_tick !== 1'b0) begin
      failures++; $display("FAIL fb_tick_len got=%b exp=0", frame_tick);
    end
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    hsync_in = 1'b1; vsync_in = 1'b1; hcount_in = 11'd7;
    repeat (3) @(negedge pclk);
    checks++;
    if ({rgb_out, hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out,
         collision, frame_tick, frame_cnt} !== '0) begin
      failures++;
      $display("FAIL reset_outs rgb=%h hc=%h hs=%b vs=%b col=%b tick=%b cnt=%h exp=all0",
               rgb_out, hcount_out, hsync_out, vsync_out, collision, frame_tick, frame_cnt);
    end
    rst_n = 1'b1; hsync_in = 1'b0; vsync_in = 1'b0; hcount_in = 11'd0;
    repeat (3) @(negedge pclk);
    hcount_in = 11'd100; vcount_in = 11'd50; hsync_in = 1'b1; vsync_in = 1'b0;
    req_in = 4'b0000;
    @(posedge pclk);
    #1 checks++;
    if (hcount_out !== 11'd0) begin
      failures++; $display("FAIL latency_early got=%0d exp=0", hcount_out);
    end
    @(posedge pclk);
    #1 checks++;
    if ({hcount_out, vcount_out, hsync_out, vsync_out} !== {11'd100, 11'd50, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL timing_d2 hc=%0d vc=%0d hs=%b vs=%b exp=100/50/1/0",
               hcount_out, vcount_out, hsync_out, vsync_out);
    end
    checks++;
    if ({rgb_out, collision, frame_cnt} !== {12'h000, 1'b0, 16'h0000}) begin
      failures++;
      $display("FAIL bg_after_reset rgb=%h col=%b cnt=%h exp=000/0/0000", rgb_out, collision, frame_cnt);
    end
  endtask

  task automatic test_priority;
    logic [11:0] got;
    rgb0_in = 12'h0F0; rgb1_in = 12'hF00; rgb2_in = 12'h00F; rgb3_in = 12'hFFF;
    pix(4'b0110, 1'b0, got);
    checks++;
    if (got !== 12'hF00) begin failures++; $display("FAIL prio_a_front got=%h exp=F00", got); end
    pix(4'b1000, 1'b0, got);
    checks++;
    if (got !== 12'hFFF) begin failures++; $display("FAIL prio_bg_sprite got=%h exp=FFF", got); end
    cfg_swap = 1'b1;
    pix(4'b0110, 1'b0, got);
    checks++;
    if (got !== 12'hF00) begin failures++; $display("FAIL swap_midframe got=%h exp=F00", got); end
    do_fb();
    pix(4'b0110, 1'b0, got);
    checks++;
    if (got !== 12'h00F) begin failures++; $display("FAIL prio_b_front got=%h exp=00F", got); end
    pix(4'b0010, 1'b0, got);
    checks++;
    if (got !== 12'hF00) begin failures++; $display("FAIL swap_a_only got=%h exp=F00", got); end
    cfg_swap = 1'b0;
    do_fb();
    pix(4'b0110, 1'b0, got);
    checks++;
    if (got !== 12'hF00) begin failures++; $display("FAIL unswap got=%h exp=F00", got); end
  endtask

  task automatic test_blank;
    logic [11:0] got;
    pix(4'b1111, 1'b1, got);
    checks++;
    if (got !== 12'h000) begin failures++; $display("FAIL blank_black got=%h exp=000", got); end
    pix(4'b1111, 1'b0, got);
    checks++;
    if (got !== 12'h0F0) begin failures++; $display("FAIL ui_top got=%h exp=0F0", got); end
  endtask

  task automatic test_enable;
    logic [11:0] got;
    cfg_en = 4'b1101;
    pix(4'b0010, 1'b0, got);
    checks++;
    if (got !== 12'hF00) begin failures++; $display("FAIL en_midframe got=%h exp=F00", got); end
    do_fb();
    pix(4'b0010, 1'b0, got);
    checks++;
    if (got !== 12'h000) begin failures++; $display("FAIL en_masked_bg got=%h exp=000", got); end
    pix(4'b1010, 1'b0, got);
    checks++;
    if (got !== 12'hFFF) begin failures++; $display("FAIL en_fallthru got=%h exp=FFF", got); end
    pix(4'b0110, 1'b0, got);
    checks++;
    if (got !== 12'h00F) begin failures++; $display("FAIL en_b_only got=%h exp=00F", got); end
    cfg_en = 4'b1111;
    do_fb();
  endtask

  task automatic test_collision;
    logic [11:0] got;
    do_fb();
    pix(4'b0110, 1'b0, got);
    pix(4'b0000, 1'b0, got);
    do_fb();
    checks++;
    if (collision !== 1'b1) begin failures++; $display("FAIL col_set got=%b exp=1", collision); end
    pix(4'b0110, 1'b1, got);
    pix(4'b0010, 1'b0, got);
    checks++;
    if (collision !== 1'b1) begin failures++; $display("FAIL col_hold got=%b exp=1", collision); end
    do_fb();
    checks++;
    if (collision !== 1'b0) begin failures++; $display("FAIL col_clear got=%b exp=0", collision); end
    cfg_en = 4'b1011;
    do_fb();
    pix(4'b0110, 1'b0, got);
    do_fb();
    checks++;
    if (collision !== 1'b0) begin failures++; $display("FAIL col_disabled got=%b exp=0", collision); end
    cfg_en = 4'b1111;
    do_fb();
  endtask

  task automatic test_reset_mid;
    logic [11:0] got;
    pix(4'b0110, 1'b0, got);
    do_fb();
    checks++;
    if (collision !== 1'b1) begin failures++; $display("FAIL rm_col_pre got=%b exp=1", collision); end
    pix(4'b0110, 1'b0, got);
    @(negedge pclk);
    #2 rst_n = 1'b0;
    #1 checks++;
    if ({collision, frame_cnt, rgb_out} !== {1'b0, 16'h0000, 12'h000}) begin
      failures++;
      $display("FAIL rm_async col=%b cnt=%h rgb=%h exp=0/0000/000", collision, frame_cnt, rgb_out);
    end
    exp_cnt = 16'h0000;
    @(negedge pclk);
    rst_n = 1'b1; req_in = 4'b0000;
    do_fb();
    checks++;
    if (collision !== 1'b0) begin failures++; $display("FAIL rm_col_post got=%b exp=0", collision); end
  endtask

  // 16x8 frame: active 12x6, hsync h=13..14, vsync v=7
  task automatic test_frames;
    int          ticks[$];
    logic [25:0] h1, h2, cur;
    int          hh, vv;
    h1 = '0; h2 = '0;
    for (int n = 0; n < 3 * 128 + 4; n++) begin
      @(negedge pclk);
      if (frame_tick === 1'b1) ticks.push_back(cyc);
      if (n >= 2) begin
        checks++;
        if ({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out} !== h2) begin
          failures++;
          $display("FAIL frame_timing n=%0d got=%h exp=%h", n,
                   {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}, h2);
        end
      end
      hh = n % 16; vv = (n / 16) % 8;
      hcount_in = 11'(hh); vcount_in = 11'(vv);
      hblnk_in = (hh >= 12); vblnk_in = (vv >= 6);
      hsync_in = (hh == 13 || hh == 14); vsync_in = (vv == 7);
      req_in = 4'b0000;
      cur = {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in};
      h2 = h1; h1 = cur;
    end
    checks++;
    if (ticks.size() != 3) begin
      failures++; $display("FAIL tick_count got=%0d exp=3", ticks.size());
    end else begin
      checks++;
      if (ticks[1] - ticks[0] != 128 || ticks[2] - ticks[1] != 128) begin
        failures++;
        $display("FAIL tick_spacing got=%0d,%0d exp=128", ticks[1] - ticks[0], ticks[2] - ticks[1]);
      end
    end
    exp_cnt = exp_cnt + 16'd3;
    checks++;
    if (frame_cnt !== exp_cnt) begin
      failures++; $display("FAIL frames_cnt got=%h exp=%h", frame_cnt, exp_cnt);
    end
  endtask

  task automatic test_wrap;
    @(negedge pclk);
    force dut.frame_cnt = 16'hFFFF;
    @(negedge pclk);
    release dut.frame_cnt;
    #1 checks++;
    if (frame_cnt !== 16'hFFFF) begin
      failures++; $display("FAIL wrap_preload got=%h exp=FFFF", frame_cnt);
    end
    exp_cnt = 16'hFFFF;
    do_fb();
    checks++;
    if (frame_cnt !== 16'h0000) begin
      failures++; $display("FAIL wrap_zero got=%h exp=0000", frame_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_blank();
    test_enable();
    test_collision();
    test_reset_mid();
    test_frames();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
